// File: rtl/down_counter.sv
// Loadable binary down-counter/timer with terminal-count pulse, optional
// auto-reload on expiry and a sticky flag for decrements requested while idle.
`timescale 1ns/1ps
module down_counter #(
  parameter int WIDTH = 40
) (
  input  logic             i_clk,
  input  logic             i_aclr,
  input  logic             i_sclr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_ld_val,
  input  logic             i_reload_en,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_busy,
  output logic             o_tc,
  output logic             o_uflow
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             uflow_q, uflow_d;

  // State and datapath registers; async clear forces every output to idle values.
  always_ff @(posedge i_clk or posedge i_aclr) begin
    if (i_aclr) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      uflow_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      uflow_q  <= uflow_d;
    end
  end

  // Next-state logic: clear beats load, load beats decrement; tc is a one-cycle pulse.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    uflow_d  = uflow_q;

    if (i_sclr) begin
      state_d  = IDLE;
      cnt_d    = '0;
      reload_d = '0;
      uflow_d  = 1'b0;
    end else if (i_load) begin
      cnt_d    = i_ld_val;
      reload_d = i_ld_val;
      uflow_d  = 1'b0;
      state_d  = (i_ld_val != '0) ? RUN : IDLE;
    end else if (i_cin) begin
      unique case (state_q)
        RUN: begin
          if (cnt_q == ONE) begin
            // Expiry: either rearm from the reload register or fall back to idle.
            tc_d = 1'b1;
            if (i_reload_en) begin
              cnt_d = reload_q;
            end else begin
              cnt_d   = '0;
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        IDLE: begin
          // Count stays pinned at zero; the request is remembered as an error.
          uflow_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign o_cnt   = cnt_q;
  assign o_busy  = (state_q == RUN);
  assign o_tc    = tc_q;
  assign o_uflow = uflow_q;

endmodule

// File: tb/tb_down_counter.sv
// Bench for down_counter: directed vector table, hand-written asynchronous
// clear sequence, then randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_down_counter;

  localparam int W = 40;

  logic         i_clk = 1'b0;
  logic         i_aclr = 1'b0;
  logic         i_sclr = 1'b0;
  logic         i_load = 1'b0;
  logic [W-1:0] i_ld_val = '0;
  logic         i_reload_en = 1'b0;
  logic         i_cin = 1'b0;
  logic [W-1:0] o_cnt;
  logic         o_busy;
  logic         o_tc;
  logic         o_uflow;

  int checks = 0;
  int errors = 0;

  down_counter #(.WIDTH(W)) dut (
    .i_clk(i_clk), .i_aclr(i_aclr), .i_sclr(i_sclr), .i_load(i_load),
    .i_ld_val(i_ld_val), .i_reload_en(i_reload_en), .i_cin(i_cin),
    .o_cnt(o_cnt), .o_busy(o_busy), .o_tc(o_tc), .o_uflow(o_uflow)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural model: "remaining" events until expiry, plus the period to reload.
  logic [W-1:0] m_remaining = '0;
  logic [W-1:0] m_period = '0;
  bit           m_armed = 0;
  bit           m_tc = 0;
  bit           m_uflow = 0;

  function automatic void model_reset();
    m_remaining = '0; m_period = '0; m_armed = 0; m_tc = 0; m_uflow = 0;
  endfunction

  function automatic void model_step(bit sclr, bit load, logic [W-1:0] val, bit ren, bit cin);
    m_tc = 0;
    if (sclr) begin
      model_reset();
    end else if (load) begin
      m_remaining = val;
      m_period    = val;
      m_armed     = (val != 0);
      m_uflow     = 0;
    end else if (cin) begin
      if (!m_armed) begin
        m_uflow = 1;
      end else begin
        m_remaining = m_remaining - 1;
        if (m_remaining == 0) begin
          m_tc = 1;
          if (ren) m_remaining = m_period;
          else m_armed = 0;
        end
      end
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input bit sclr, input bit load, input logic [W-1:0] val,
                       input bit ren, input bit cin);
    i_sclr = sclr; i_load = load; i_ld_val = val; i_reload_en = ren; i_cin = cin;
    @(posedge i_clk);
    model_step(sclr, load, val, ren, cin);
    #1;
  endtask

  typedef struct {
    bit           sclr;
    bit           load;
    logic [W-1:0] val;
    bit           ren;
    bit           cin;
    logic [W-1:0] ecnt;
    bit           ebusy;
    bit           etc;
    bit           euf;
  } vec_t;

  vec_t vt[$];

  function automatic void add(bit sclr, bit load, logic [W-1:0] val, bit ren, bit cin,
                              logic [W-1:0] ecnt, bit ebusy, bit etc, bit euf);
    vec_t v;
    v.sclr = sclr; v.load = load; v.val = val; v.ren = ren; v.cin = cin;
    v.ecnt = ecnt; v.ebusy = ebusy; v.etc = etc; v.euf = euf;
    vt.push_back(v);
  endfunction

  initial begin
    // One-shot from 5 with cin held high
    add(0,1,5,0,1, 5,1,0,0);
    add(0,0,0,0,1, 4,1,0,0);
    add(0,0,0,0,1, 3,1,0,0);
    add(0,0,0,0,1, 2,1,0,0);
    add(0,0,0,0,1, 1,1,0,0);
    add(0,0,0,0,1, 0,0,1,0);
    add(0,0,0,0,0, 0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0);
    // Auto-reload period 3
    add(0,1,3,1,1, 3,1,0,0);
    add(0,0,0,1,1, 2,1,0,0);
    add(0,0,0,1,1, 1,1,0,0);
    add(0,0,0,1,1, 3,1,1,0);
    add(0,0,0,1,1, 2,1,0,0);
    add(0,0,0,1,1, 1,1,0,0);
    add(0,0,0,1,1, 3,1,1,0);
    // Gated decrement
    add(0,1,4,0,0, 4,1,0,0);
    add(0,0,0,0,1, 3,1,0,0);
    add(0,0,0,0,0, 3,1,0,0);
    add(0,0,0,0,1, 2,1,0,0);
    add(0,0,0,0,0, 2,1,0,0);
    // Reload mid-run with cin high: no decrement in the load cycle
    add(0,1,10,0,1, 10,1,0,0);
    add(0,0,0,0,1, 9,1,0,0);
    add(0,0,0,0,1, 8,1,0,0);
    add(0,0,0,0,1, 7,1,0,0);
    add(0,0,0,0,1, 6,1,0,0);
    add(0,1,2,0,1, 2,1,0,0);
    add(0,0,0,0,1, 1,1,0,0);
    add(0,0,0,0,1, 0,0,1,0);
    // Load zero then decrement request: underflow flag, cleared by load
    add(0,1,0,0,1, 0,0,0,0);
    add(0,0,0,0,1, 0,0,0,1);
    add(0,0,0,0,0, 0,0,0,1);
    add(0,1,7,0,0, 7,1,0,0);
    // Sync clear wins over load
    add(1,1,9,0,1, 0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0);
    // Load at the expiry edge wins, no tc
    add(0,1,2,0,1, 2,1,0,0);
    add(0,0,0,0,1, 1,1,0,0);
    add(0,1,5,0,1, 5,1,0,0);
    add(0,0,0,0,1, 4,1,0,0);
    // Maximum load value
    add(0,1,40'hFF_FFFF_FFFF,0,0, 40'hFF_FFFF_FFFF,1,0,0);
    add(0,0,0,0,1, 40'hFF_FFFF_FFFE,1,0,0);
    add(0,0,0,0,1, 40'hFF_FFFF_FFFD,1,0,0);
  end

  initial begin
    // Reset state
    i_aclr = 1'b1;
    #1;
    chk("rst_async_cnt", o_cnt, 0);
    chk("rst_async_busy", o_busy, 0);
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_cnt", o_cnt, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_tc", o_tc, 0);
    chk("rst_uflow", o_uflow, 0);
    i_aclr = 1'b0;
    model_reset();

    // Directed table
    #0;
    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i].sclr, vt[i].load, vt[i].val, vt[i].ren, vt[i].cin);
      chk($sformatf("vec%0d_cnt", i), o_cnt, vt[i].ecnt);
      chk($sformatf("vec%0d_busy", i), o_busy, vt[i].ebusy);
      chk($sformatf("vec%0d_tc", i), o_tc, vt[i].etc);
      chk($sformatf("vec%0d_uflow", i), o_uflow, vt[i].euf);
    end

    // Asynchronous clear between edges mid-run
    apply(0,1,40'h12_3456_789A,1,0);
    chk("aclr_pre_cnt", o_cnt, 40'h12_3456_789A);
    #2 i_aclr = 1'b1;
    #1;
    chk("aclr_now_cnt", o_cnt, 0);
    chk("aclr_now_busy", o_busy, 0);
    chk("aclr_now_tc", o_tc, 0);
    #1 i_aclr = 1'b0;
    model_reset();
    apply(0,0,0,1,1);
    chk("aclr_after_cnt", o_cnt, 0);
    chk("aclr_after_busy", o_busy, 0);
    chk("aclr_after_uflow", o_uflow, 1);
    apply(0,0,0,1,1);
    chk("aclr_after2_cnt", o_cnt, 0);
    chk("aclr_after2_tc", o_tc, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bit           rs, rl, rr, rc;
      logic [W-1:0] rv;
      rs = ($urandom_range(0, 63) == 0);
      rl = ($urandom_range(0, 9) == 0);
      rr = $urandom_range(0, 1);
      rc = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       rv = '0;
        1:       rv = {$urandom, $urandom};
        default: rv = W'($urandom_range(1, 12));
      endcase
      apply(rs, rl, rv, rr, rc);
      chk("rnd_cnt", o_cnt, m_remaining);
      chk("rnd_busy", o_busy, m_armed);
      chk("rnd_tc", o_tc, m_tc);
      chk("rnd_uflow", o_uflow, m_uflow);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/down_counter.md
# down_counter

Loadable 40-bit binary down-counter/timer: the counting-down counterpart of the team's 40-bit up-counter. A value is loaded, then decremented once per cycle in which the count-enable is high. The block flags terminal count on reaching zero and can optionally auto-reload for periodic operation. It sits beside the up-counter in the timing/event-counting path and provides timeouts, periodic ticks and "N events remaining" detection.

## Interface
- WIDTH, 40, counter and load-value width in bits
- i_clk  input  1  rising-edge clock
- i_aclr  input  1  asynchronous, active-high reset; clears all state immediately
- i_sclr  input  1  synchronous clear, active-high
- i_load  input  1  load strobe; captures i_ld_val into the counter and the reload register
- i_ld_val  input  WIDTH  value to load
- i_reload_en  input  1  1 = auto-reload on expiry, 0 = one-shot
- i_cin  input  1  decrement enable; one decrement per cycle while high
- o_cnt  output  WIDTH  current count
- o_busy  output  1  high while in RUN
- o_tc  output  1  terminal-count pulse, one cycle per expiry
- o_uflow  output  1  sticky error flag: decrement requested while in IDLE

## Operation
- States:
  - IDLE: count is 0, not armed.
  - RUN: armed and decrementing.
  - Internal register r_reload holds WIDTH bits.
- Priority on each rising edge, highest first: i_sclr, then i_load, then i_cin. i_aclr overrides everything asynchronously.
- i_aclr=1: o_cnt=0, r_reload=0, state=IDLE, o_busy=0, o_tc=0, o_uflow=0. These are the reset values of every output. Effect is immediate and does not wait for a clock edge.
- i_sclr=1: same values as i_aclr, applied at the clock edge. Load and cin in the same cycle are ignored.
- i_load=1:
  - o_cnt <= i_ld_val and r_reload <= i_ld_val.
  - o_uflow <= 0 and o_tc <= 0.
  - state <= RUN if i_ld_val != 0, else IDLE.
  - No decrement occurs in the load cycle, even if i_cin=1.
- RUN with i_cin=1, no load:
  - o_cnt > 1: o_cnt <= o_cnt - 1.
  - o_cnt == 1 (expiry): o_tc <= 1.
    - If i_reload_en=1: o_cnt <= r_reload and state stays RUN.
    - If i_reload_en=0: o_cnt <= 0 and state <= IDLE.
- RUN with i_cin=0: hold o_cnt.
- IDLE with i_cin=1: o_cnt stays 0 (never wraps to all-ones) and o_uflow <= 1. o_uflow is cleared only by reset, i_sclr or i_load.
- o_tc is 0 in every cycle other than the one following an expiry.
- i_reload_en is sampled only at the expiry edge. It may change freely at other times.
- Arithmetic: unsigned, WIDTH bits. The maximum load is 2^WIDTH-1, which gives exactly 2^WIDTH-1 decrements to expiry.

## Timing
- Every output is registered, with no combinational path from input to output.
- Load latency is one cycle: o_cnt shows i_ld_val at the edge after i_load is sampled.
- Expiry:
  - o_tc is high for exactly one cycle.
  - That cycle coincides with o_cnt showing 0 (one-shot) or r_reload (auto-reload).
- With i_cin held high after loading N with auto-reload on, o_tc pulses every N cycles.
- o_busy = (state==RUN). It falls in the same cycle that o_tc rises for a one-shot expiry.
- Load at the expiry edge: the load wins, o_tc stays 0 and the new value is taken.
- Reset asserted mid-RUN: outputs go to reset values at once. After release, the block stays IDLE until the next i_load.

## Test plan
- Reset, then i_load with i_ld_val=5 and i_cin held high, i_reload_en=0. Required: o_cnt=5,4,3,2,1,0 on consecutive cycles; o_tc=1 only on the cycle o_cnt=0; o_busy drops on that cycle; o_cnt then stays 0.
- Load 3 with i_reload_en=1 and i_cin held high. Required: o_cnt=3,2,1,3,2,1,3; o_tc pulses in every cycle where o_cnt returns to 3 after a 1; o_busy stays 1.
- Load 4, then toggle i_cin 1,0,1,0. Required: o_cnt=4,3,3,2,2.
- Load 10, run to 6, then i_load with 2 while i_cin=1. Required: o_cnt=2 (no decrement in the load cycle), then 1, then 0 with o_tc.
- Load 0, then drive i_cin=1. Required: o_busy=0, no o_tc, o_cnt=0, o_uflow=1. A following i_load clears o_uflow.
- Simultaneous events:
  - i_sclr and i_load in the same cycle: the clear wins.
  - i_aclr asserted between edges mid-RUN at count 0x12_3456_789A: o_cnt=0 immediately.
  - Load 0xFF_FFFF_FFFF: the first decrement gives 0xFF_FFFF_FFFE, with no spurious o_tc.
